// File: rtl/polyline_pkg.sv
// Shared types for the polyline sequencer: FSM state encoding, default
// coordinate width and the vertex record used by the surrounding top level.
package polyline_pkg;

    localparam int COORD_W_DEFAULT = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH0 = 3'd1,
        LATCH0 = 3'd2,
        FETCH  = 3'd3,
        LATCH  = 3'd4,
        ISSUE  = 3'd5,
        WAIT   = 3'd6,
        DONE   = 3'd7
    } ps_state_t;

    typedef struct packed {
        logic [COORD_W_DEFAULT-1:0] x;
        logic [COORD_W_DEFAULT-1:0] y;
    } vert_t;

endpackage

// File: rtl/polyline_sequencer.sv
// Walks a vertex list held in an external 1-cycle-latency store and hands
// line_drawer one segment at a time, optionally closing the polygon.
module polyline_sequencer
    import polyline_pkg::*;
#(
    parameter int COORD_W   = COORD_W_DEFAULT,
    parameter int MAX_VERTS = 16,
    parameter int IDX_W     = $clog2(MAX_VERTS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [IDX_W:0]     n_verts,
    input  logic               closed,
    input  logic               erase,
    output logic [IDX_W-1:0]   vert_addr,
    input  logic [COORD_W-1:0] vert_x,
    input  logic [COORD_W-1:0] vert_y,
    output logic [COORD_W-1:0] x0,
    output logic [COORD_W-1:0] y0,
    output logic [COORD_W-1:0] x1,
    output logic [COORD_W-1:0] y1,
    output logic               ld_start,
    input  logic               ld_done,
    output logic               pixel_color,
    output logic               busy,
    output logic               frame_done,
    output logic [2:0]         dbg_state
);

    // Drawer handshake: ld_start is a one-cycle pulse with x0..y1 already
    // valid; the endpoints hold until the drawer answers with a one-cycle
    // ld_done, which is only consumed in WAIT (ignored everywhere else).

    localparam logic [IDX_W:0]   MAX_N   = (IDX_W+1)'(MAX_VERTS);
    localparam logic [IDX_W:0]   N_ONE   = (IDX_W+1)'(1);
    localparam logic [IDX_W:0]   N_TWO   = (IDX_W+1)'(2);
    localparam logic [IDX_W:0]   N_THREE = (IDX_W+1)'(3);
    localparam logic [IDX_W-1:0] I_ONE   = IDX_W'(1);

    ps_state_t          state;
    logic [IDX_W:0]     n_eff;
    logic [IDX_W:0]     n_q;
    logic               closed_q;
    logic               closing;
    logic [IDX_W-1:0]   i;
    logic [COORD_W-1:0] first_x, first_y;
    logic [COORD_W-1:0] prev_x, prev_y;
    logic [COORD_W-1:0] cur_x, cur_y;

    assign n_eff     = (n_verts > MAX_N) ? MAX_N : n_verts;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            n_q         <= '0;
            closed_q    <= 1'b0;
            closing     <= 1'b0;
            i           <= '0;
            first_x     <= '0;
            first_y     <= '0;
            prev_x      <= '0;
            prev_y      <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            vert_addr   <= '0;
            x0          <= '0;
            y0          <= '0;
            x1          <= '0;
            y1          <= '0;
            ld_start    <= 1'b0;
            pixel_color <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            ld_start   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pixel_color <= ~erase;
                        busy        <= 1'b1;
                        if (n_eff < N_TWO) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            n_q       <= n_eff;
                            closed_q  <= closed;
                            closing   <= 1'b0;
                            i         <= '0;
                            vert_addr <= '0;
                            state     <= FETCH0;
                        end
                    end
                end
                FETCH0: state <= LATCH0;
                LATCH0: begin
                    first_x   <= vert_x;
                    first_y   <= vert_y;
                    prev_x    <= vert_x;
                    prev_y    <= vert_y;
                    i         <= I_ONE;
                    vert_addr <= I_ONE;
                    state     <= FETCH;
                end
                FETCH: state <= LATCH;
                LATCH: begin
                    // Endpoints are loaded together with the pulse so they
                    // are already valid in the ISSUE cycle.
                    cur_x    <= vert_x;
                    cur_y    <= vert_y;
                    x0       <= prev_x;
                    y0       <= prev_y;
                    x1       <= vert_x;
                    y1       <= vert_y;
                    ld_start <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (ld_done) begin
                        prev_x <= cur_x;
                        prev_y <= cur_y;
                        if (closing) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else if ({1'b0, i} < n_q - N_ONE) begin
                            i         <= i + I_ONE;
                            vert_addr <= i + I_ONE;
                            state     <= FETCH;
                        end else if (closed_q && n_q >= N_THREE) begin
                            cur_x    <= first_x;
                            cur_y    <= first_y;
                            closing  <= 1'b1;
                            x0       <= cur_x;
                            y0       <= cur_y;
                            x1       <= first_x;
                            y1       <= first_y;
                            ld_start <= 1'b1;
                            state    <= ISSUE;
                        end else begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_polyline_sequencer.sv
// Frame-level bench: a table of frame requests, a vertex ROM and drawer
// model, and a segment scoreboard filled when each frame is started.
module tb_polyline_sequencer;
    import polyline_pkg::*;

    localparam int COORD_W = COORD_W_DEFAULT;
    localparam int MAXV    = 16;
    localparam int IDX_W   = 4;
    localparam int SEG_W   = 4 * COORD_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [IDX_W:0]     n_verts;
    logic               closed;
    logic               erase;
    logic [IDX_W-1:0]   vert_addr;
    logic [COORD_W-1:0] vert_x, vert_y;
    logic [COORD_W-1:0] x0, y0, x1, y1;
    logic               ld_start;
    logic               ld_done;
    logic               pixel_color;
    logic               busy;
    logic               frame_done;
    logic [2:0]         dbg_state;

    typedef struct {
        logic [IDX_W:0] n_verts;
        bit             closed;
        bit             erase;
        bit             poke;
        int             exp_segs;
    } frame_t;

    vert_t            vmem [MAXV];
    frame_t           frames [8];
    logic [SEG_W-1:0] exp_q [$];
    int               n_vec = 0;
    int               n_err = 0;

    // clock / reset
    always #5 clk = ~clk;

    polyline_sequencer #(
        .COORD_W   (COORD_W),
        .MAX_VERTS (MAXV),
        .IDX_W     (IDX_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .n_verts     (n_verts),
        .closed      (closed),
        .erase       (erase),
        .vert_addr   (vert_addr),
        .vert_x      (vert_x),
        .vert_y      (vert_y),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .ld_start    (ld_start),
        .ld_done     (ld_done),
        .pixel_color (pixel_color),
        .busy        (busy),
        .frame_done  (frame_done),
        .dbg_state   (dbg_state)
    );

    // vertex store with one cycle of read latency
    always @(posedge clk) begin
        vert_x <= vmem[vert_addr].x;
        vert_y <= vmem[vert_addr].y;
    end

    function automatic void chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [SEG_W-1:0] seg(input int a, input int b);
        return {vmem[a].x, vmem[a].y, vmem[b].x, vmem[b].y};
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_x0"}, x0, 0);
        chk({tag, "_y0"}, y0, 0);
        chk({tag, "_x1"}, x1, 0);
        chk({tag, "_y1"}, y1, 0);
        chk({tag, "_vert_addr"}, vert_addr, 0);
        chk({tag, "_ld_start"}, ld_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_pixel_color"}, pixel_color, 0);
        chk({tag, "_state"}, dbg_state, IDLE);
    endtask

    // Driver + monitor for one frame; cycle 0 is the cycle start is high.
    task automatic run_frame(input frame_t f, input int k);
        int               n_eff, segs, done_at, last_done, issue_cyc, max_addr, exp_lat;
        bit               seen_fd, have_seg;
        logic [SEG_W-1:0] cur_exp;
        string            tag;
        tag       = $sformatf("f%0d", k);
        n_eff     = (int'(f.n_verts) > MAXV) ? MAXV : int'(f.n_verts);
        for (int s = 0; s < n_eff - 1; s++) exp_q.push_back(seg(s, s + 1));
        if (f.closed && n_eff >= 3) exp_q.push_back(seg(n_eff - 1, 0));
        segs      = 0;
        done_at   = -1;
        last_done = -1;
        issue_cyc = -1;
        max_addr  = 0;
        seen_fd   = 0;
        have_seg  = 0;
        cur_exp   = '0;
        @(negedge clk);
        start   = 1'b1;
        n_verts = f.n_verts;
        closed  = f.closed;
        erase   = f.erase;
        ld_done = 1'b0;
        for (int cyc = 1; cyc <= 400 && !seen_fd; cyc++) begin
            @(negedge clk);
            if (cyc == 1) chk({tag, "_busy_rise"}, busy, 1);
            if (int'(vert_addr) > max_addr) max_addr = int'(vert_addr);
            if (ld_start) begin
                if (segs == 0) chk({tag, "_first_ld_start_cycle"}, cyc, 5);
                else begin
                    exp_lat = (f.closed && n_eff >= 3 && segs == n_eff - 1) ? 1 : 3;
                    chk({tag, "_ld_start_latency"}, cyc - last_done, exp_lat);
                end
                if (exp_q.size() == 0) begin
                    chk({tag, "_unexpected_ld_start"}, 1, 0);
                    have_seg = 0;
                end else begin
                    cur_exp = exp_q.pop_front();
                    chk({tag, "_segment"}, {x0, y0, x1, y1}, cur_exp);
                    have_seg = 1;
                end
                chk({tag, "_pixel_color"}, pixel_color, !f.erase);
                if (segs == 0) issue_cyc = cyc;
                segs++;
                done_at = cyc + int'($urandom_range(1, 4));
            end
            if (cyc == done_at && have_seg)
                chk({tag, "_endpoints_held"}, {x0, y0, x1, y1}, cur_exp);
            if (frame_done) begin
                seen_fd = 1;
                chk({tag, "_frame_done_cycle"}, cyc, (n_eff < 2) ? 1 : last_done + 1);
            end
            start   = 1'b0;
            ld_done = (cyc == done_at);
            if (ld_done) last_done = cyc;
            if (f.poke && segs == 1 && cyc == issue_cyc + 1) begin
                start   = 1'b1;
                n_verts = 5'd5;
            end
        end
        ld_done = 1'b0;
        start   = 1'b0;
        if (!seen_fd) chk({tag, "_frame_done_timeout"}, 0, 1);
        chk({tag, "_segment_count"}, segs, f.exp_segs);
        chk({tag, "_scoreboard_left"}, exp_q.size(), 0);
        exp_q.delete();
        if (n_eff >= 2) chk({tag, "_max_vert_addr"}, max_addr, n_eff - 1);
        @(negedge clk);
        chk({tag, "_busy_fall"}, busy, 0);
        chk({tag, "_back_to_idle"}, dbg_state, IDLE);
    endtask

    initial begin
        int got, n_ls, n_busy;
        reset   = 1'b1;
        start   = 1'b0;
        n_verts = '0;
        closed  = 1'b0;
        erase   = 1'b0;
        ld_done = 1'b0;
        vmem[0] = '{x: 11'd64,  y: 11'd96};
        vmem[1] = '{x: 11'd192, y: 11'd192};
        vmem[2] = '{x: 11'd320, y: 11'd288};
        for (int v = 3; v < MAXV; v++) begin
            vmem[v].x = COORD_W'($urandom_range(0, 2047));
            vmem[v].y = COORD_W'($urandom_range(0, 2047));
        end
        // n_verts, closed, erase, poke, expected segment count
        frames[0] = '{5'd3,  1'b0, 1'b0, 1'b0, 2};
        frames[1] = '{5'd3,  1'b1, 1'b1, 1'b0, 3};
        frames[2] = '{5'd0,  1'b1, 1'b0, 1'b0, 0};
        frames[3] = '{5'd1,  1'b1, 1'b0, 1'b0, 0};
        frames[4] = '{5'd3,  1'b0, 1'b0, 1'b1, 2};
        frames[5] = '{5'd20, 1'b1, 1'b0, 1'b0, 16};
        frames[6] = '{5'd2,  1'b1, 1'b1, 1'b0, 1};
        frames[7] = '{5'd16, 1'b0, 1'b0, 1'b0, 15};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_zero("reset");

        for (int k = 0; k < 8; k++) run_frame(frames[k], k);

        // reset while waiting on the drawer for the first segment
        @(negedge clk);
        start   = 1'b1;
        n_verts = 5'd3;
        closed  = 1'b0;
        erase   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        got   = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            @(negedge clk);
            if (ld_start) got = 1;
        end
        chk("rst_seq_ld_start_seen", got, 1);
        @(negedge clk);
        chk("rst_seq_in_wait", dbg_state, WAIT);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_zero("reset_in_wait");
        ld_done = 1'b1;
        @(negedge clk);
        ld_done = 1'b0;
        n_ls   = 0;
        n_busy = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ld_start) n_ls++;
            if (busy) n_busy++;
        end
        chk("late_ld_done_ld_start", n_ls, 0);
        chk("late_ld_done_busy", n_busy, 0);
        run_frame(frames[0], 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
